// File: rtl/fifo_rd_burst_drain.sv
// Read-side burst drain: pops whole 2^BURST_LOG-word bursts from a FWFT FIFO onto a registered valid/stall stream.
// Optional header word per burst when FIFO_RD_BURST_HDR_EN is defined.
module fifo_rd_burst_drain #(
  parameter int BURST_LOG = 3,
  parameter int WORDS_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic [31:0]        i_fifo_data,
  input  logic               i_fifo_empty,
  input  logic [WORDS_W-1:0] i_fifo_words,
  output logic               o_fifo_rd_en,
  output logic [31:0]        o_data,
  output logic               o_valid,
  output logic               o_first,
  output logic               o_last,
  input  logic               i_stall,
  output logic               o_busy
);

  localparam logic [31:0] BURST_LEN = 32'd1 << BURST_LOG;
  localparam int          CMP_W     = (WORDS_W > 10) ? WORDS_W : 10;
  localparam logic [BURST_LOG:0] LAST_CNT = (BURST_LOG + 1)'(BURST_LEN - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef FIFO_RD_BURST_HDR_EN
    HDR   = 2'd1,
`endif
    BURST = 2'd2
  } state_t;

  state_t             state_r;
  logic [BURST_LOG:0] cnt_r;
  logic               load_s;
  logic               start_s;
  logic               last_pop_s;
`ifdef FIFO_RD_BURST_HDR_EN
  logic [15:0]        seq_r;
`endif

  // Occupancy widened so the threshold compare never truncates the burst length.
  assign start_s    = i_enable & (CMP_W'(i_fifo_words) >= CMP_W'(BURST_LEN));
  assign load_s     = ~o_valid | ~i_stall;
  assign o_fifo_rd_en = (state_r == BURST) & ~i_fifo_empty & load_s;
  assign last_pop_s = (cnt_r == LAST_CNT);

  // Burst FSM with the registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {(BURST_LOG+1){1'b0}};
      o_data  <= 32'h0000_0000;
      o_valid <= 1'b0;
      o_first <= 1'b0;
      o_last  <= 1'b0;
      o_busy  <= 1'b0;
`ifdef FIFO_RD_BURST_HDR_EN
      seq_r   <= 16'h0000;
`endif
    end else begin
      // Accepted word with nothing new to load drains the output register.
      if (~i_stall) begin
        o_valid <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (start_s) begin
            cnt_r  <= {(BURST_LOG+1){1'b0}};
            o_busy <= 1'b1;
`ifdef FIFO_RD_BURST_HDR_EN
            state_r <= HDR;
`else
            state_r <= BURST;
`endif
          end
        end
`ifdef FIFO_RD_BURST_HDR_EN
        HDR: begin
          if (load_s) begin
            o_data  <= {8'hA5, 8'h00, seq_r};
            o_valid <= 1'b1;
            o_first <= 1'b1;
            o_last  <= 1'b0;
            seq_r   <= seq_r + 16'd1;
            state_r <= BURST;
          end
        end
`endif
        BURST: begin
          if (o_fifo_rd_en) begin
            o_data  <= i_fifo_data;
            o_valid <= 1'b1;
`ifdef FIFO_RD_BURST_HDR_EN
            o_first <= 1'b0;
`else
            o_first <= (cnt_r == {(BURST_LOG+1){1'b0}});
`endif
            o_last  <= last_pop_s;
            cnt_r   <= cnt_r + {{BURST_LOG{1'b0}}, 1'b1};
            if (last_pop_s) begin
              state_r <= IDLE;
              o_busy  <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_burst_drain.sv
// Directed bench for fifo_rd_burst_drain with a behavioural FWFT FIFO model on the read side.
module tb_fifo_rd_burst_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic [31:0] i_fifo_data;
  logic        i_fifo_empty;
  logic [9:0]  i_fifo_words;
  logic        o_fifo_rd_en;
  logic [31:0] o_data;
  logic        o_valid, o_first, o_last, o_busy;
  logic        i_stall;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          cyc    = 0;
  int          pops[$];
  logic [33:0] acc[$];

  always #5 clk = ~clk;

  fifo_rd_burst_drain #(.BURST_LOG(3), .WORDS_W(10)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_fifo_data(i_fifo_data),
    .i_fifo_empty(i_fifo_empty), .i_fifo_words(i_fifo_words), .o_fifo_rd_en(o_fifo_rd_en),
    .o_data(o_data), .o_valid(o_valid), .o_first(o_first), .o_last(o_last),
    .i_stall(i_stall), .o_busy(o_busy)
  );

  assign i_fifo_data  = mem[rd_ptr];
  assign i_fifo_empty = (wr_ptr == rd_ptr);
  assign i_fifo_words = 10'(wr_ptr - rd_ptr);

  // FIFO pop side plus a log of pop cycles and accepted output words.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_fifo_rd_en) begin
      rd_ptr <= rd_ptr + 1;
      pops.push_back(cyc);
    end
    if (o_valid && !i_stall) acc.push_back({o_first, o_last, o_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    pops.delete();
    acc.delete();
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (pops.size() >= n) break;
      @(negedge clk);
    end
    chk("pop_wait", 32'(pops.size()), 32'(n));
  endtask

  // Checks n accepted words starting at acc[base]: data base_val+i, framing every 8.
  task automatic chk_stream(input string tag, input int base, input int n, input logic [31:0] base_val);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"},  {30'd0, 2'd0} | acc[base+i][31:0], base_val + 32'(i));
      chk({tag, "_first"}, 32'(acc[base+i][33]), 32'((i % 8) == 0));
      chk({tag, "_last"},  32'(acc[base+i][32]), 32'((i % 8) == 7));
    end
  endtask

  initial begin
    rst = 1'b1; i_enable = 1'b0; i_stall = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data",  o_data, 32'd0);
    chk("rst_first", 32'(o_first), 32'd0);
    chk("rst_last",  32'(o_last), 32'd0);
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_rden",  32'(o_fifo_rd_en), 32'd0);
    rst = 1'b0;
    i_enable = 1'b1;
    cycles(2);

`ifdef FIFO_RD_BURST_HDR_EN
    for (int i = 0; i < 16; i++) wr(32'h30 + 32'(i));
    cycles(40);
    chk("hdr_count", 32'(acc.size()), 32'd18);
    chk("hdr0", acc[0][31:0], 32'hA500_0000);
    chk("hdr0_first", 32'(acc[0][33]), 32'd1);
    chk("hdr1", acc[9][31:0], 32'hA500_0001);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) begin
        chk("hdr_dat",   acc[b*9+1+i][31:0], 32'h30 + 32'(b*8 + i));
        chk("hdr_dfirst", 32'(acc[b*9+1+i][33]), 32'd0);
        chk("hdr_dlast",  32'(acc[b*9+1+i][32]), 32'(i == 7));
      end
    end
    force dut.seq_r = 16'hFFFF;
    #1 release dut.seq_r;
    clear_logs();
    for (int i = 0; i < 16; i++) wr(32'h40 + 32'(i));
    cycles(40);
    chk("wrap_count", 32'(acc.size()), 32'd18);
    chk("hdr_ffff", acc[0][31:0], 32'hA500_FFFF);
    chk("hdr_wrap", acc[9][31:0], 32'hA500_0000);
`else
    // Threshold: 7 words do not start a burst, the 8th does.
    for (int i = 0; i < 7; i++) wr(32'h10 + 32'(i));
    cycles(5);
    chk("below_thr_pops", 32'(pops.size()), 32'd0);
    chk("below_thr_busy", 32'(o_busy), 32'd0);
    wr(32'h17);
    cycles(15);
    chk("b1_pops", 32'(pops.size()), 32'd8);
    chk("b1_consec", 32'(pops[7] - pops[0]), 32'd7);
    chk("b1_count", 32'(acc.size()), 32'd8);
    chk_stream("b1", 0, 8, 32'h10);
    clear_logs();

    // Stall for 4 cycles while 0x22 is presented.
    for (int i = 0; i < 8; i++) wr(32'h20 + 32'(i));
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (o_valid && o_data == 32'h22) begin found = 1'b1; break; end
        @(negedge clk);
      end
      chk("stall_find", 32'(found), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      i_stall = 1'b1;
      #1;
      chk("stall_data",  o_data, 32'h22);
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_rden",  32'(o_fifo_rd_en), 32'd0);
      @(negedge clk);
    end
    i_stall = 1'b0;
    cycles(15);
    chk("stall_count", 32'(acc.size()), 32'd8);
    chk_stream("stall", 0, 8, 32'h20);
    clear_logs();

    // Back-to-back bursts: one non-popping cycle between them.
    for (int i = 0; i < 16; i++) wr(32'h30 + 32'(i));
    cycles(30);
    chk("bb_pops", 32'(pops.size()), 32'd16);
    chk("bb_run1", 32'(pops[7] - pops[0]), 32'd7);
    chk("bb_gap",  32'(pops[8] - pops[7]), 32'd2);
    chk("bb_run2", 32'(pops[15] - pops[8]), 32'd7);
    chk("bb_count", 32'(acc.size()), 32'd16);
    chk_stream("bb", 0, 16, 32'h30);
    clear_logs();

    // Reset mid-burst after 3 pops.
    for (int i = 0; i < 8; i++) wr(32'h40 + 32'(i));
    wait_pops(3, 20);
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(o_valid), 32'd0);
    chk("mrst_data",  o_data, 32'd0);
    chk("mrst_first", 32'(o_first), 32'd0);
    chk("mrst_last",  32'(o_last), 32'd0);
    chk("mrst_busy",  32'(o_busy), 32'd0);
    chk("mrst_rden",  32'(o_fifo_rd_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    cycles(3);
    chk("mrst_retained", 32'(wr_ptr - rd_ptr), 32'd5);
    chk("mrst_nopop", 32'(pops.size()), 32'd0);
    for (int i = 0; i < 3; i++) wr(32'h48 + 32'(i));
    cycles(15);
    chk("mrst_count", 32'(acc.size()), 32'd8);
    chk_stream("mrst", 0, 8, 32'h43);
    clear_logs();

    // Enable gating, and dropping enable mid-burst.
    i_enable = 1'b0;
    for (int i = 0; i < 20; i++) wr(32'h50 + 32'(i));
    cycles(6);
    chk("dis_pops", 32'(pops.size()), 32'd0);
    i_enable = 1'b1;
    wait_pops(10, 30);
    i_enable = 1'b0;
    cycles(30);
    chk("en_pops", 32'(pops.size()), 32'd16);
    chk("en_left", 32'(wr_ptr - rd_ptr), 32'd4);
    chk("en_busy", 32'(o_busy), 32'd0);
    chk("en_count", 32'(acc.size()), 32'd16);
    chk_stream("en", 0, 16, 32'h50);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_burst_drain.md
# fifo_rd_burst_drain

Read-side drain controller for the aligned-clock FIFOs (512x32 and siblings). It sits in the FIFO's read clock domain and watches the FIFO read-side occupancy. Once a full burst of 2^BURST_LOG words is present, it pops exactly that many words. The words go out on a registered valid/stall stream with first/last framing, so downstream consumers always receive whole bursts and never see a partial one.

## Interface

Parameters:
- BURST_LOG, default 3: burst length is 2^BURST_LOG words; legal range 0..8.
- WORDS_W, default 10: width of the FIFO occupancy input.

Ports:
- clk  in  1  block clock; same clock as the FIFO read side.
- rst  in  1  reset; asynchronous, active-high.
- i_enable  in  1  permits new bursts to start; does not abort a burst in progress.
- i_fifo_data  in  32  FIFO head word, first-word-fall-through; valid whenever i_fifo_empty is low.
- i_fifo_empty  in  1  FIFO empty.
- i_fifo_words  in  WORDS_W  FIFO read-side occupancy; conservative, never overstates.
- o_fifo_rd_en  out  1  pop strobe; combinational from state and stall.
- o_data  out  32  output word, registered.
- o_valid  out  1  o_data valid, registered.
- o_first  out  1  first word of a burst; qualified by o_valid.
- o_last  out  1  last word of a burst; qualified by o_valid.
- i_stall  in  1  downstream cannot accept this cycle.
- o_busy  out  1  high from burst start until the last word is popped.

## Operation

- States: IDLE, HDR (present only with the macro), BURST.
- IDLE -> BURST when i_enable = 1 and i_fifo_words >= 2^BURST_LOG. The burst counter (BURST_LOG+1 bits) is loaded with 0.
- BURST:
  - o_fifo_rd_en = ~i_fifo_empty & (~o_valid | ~i_stall).
  - Each pop loads i_fifo_data into o_data, sets o_valid, and increments the counter.
  - o_first is set on pop 0; o_last is set on pop 2^BURST_LOG-1.
  - After the last pop, the FSM goes to IDLE.
- Output register update rule: it loads only when (~o_valid | ~i_stall). When no load occurs and ~i_stall, o_valid clears. When i_stall = 1 with o_valid = 1, o_data, o_first and o_last hold unchanged.
- Emptiness during a burst: this block is the FIFO's only reader and occupancy is conservative, so i_fifo_empty cannot rise mid-burst. If it does anyway, popping pauses and resumes without loss.
- i_enable falling mid-burst: the burst completes and no new burst starts.
- Reset: takes effect immediately and asynchronously.
  - State -> IDLE; counter and sequence counter -> 0.
  - o_data = 0, o_valid = 0, o_first = 0, o_last = 0, o_busy = 0, o_fifo_rd_en = 0.
  - A partially drained burst is abandoned; FIFO contents are not touched.

## Timing

- Cycle N: threshold met in IDLE. N+1: first pop (BURST, o_busy = 1). N+2: first o_valid.
- With no stall, a burst takes 2^BURST_LOG consecutive pop cycles and the valid words are back-to-back.
- Minimum gap between bursts: one IDLE cycle. The next burst's first pop is no earlier than 2 cycles after the previous last pop.
- The stall-to-pop path is combinational: a cycle with o_valid & i_stall has o_fifo_rd_en = 0.
- BURST_LOG = 0: every burst is one word, with o_first = o_last = 1.

## Configuration

- FIFO_RD_BURST_HDR_EN defined:
  - IDLE -> HDR on start.
  - HDR loads o_data = {8'hA5, 8'h00, seq[15:0]} with o_first = 1, without popping. It then goes to BURST under the same load rule.
  - The data words then carry o_first = 0; o_last still marks the final data word.
  - seq is a 16-bit counter that increments after each header is accepted and wraps 0xFFFF -> 0x0000.
  - Latency to the first data word grows by one cycle.
- Undefined: no HDR state and no seq counter; behaviour is exactly as above.

## Test plan

- BURST_LOG = 3; FIFO holds 7 words 0x10..0x16 -> no o_fifo_rd_en. Write 0x17 -> 8 consecutive pops; o_data 0x10..0x17 on 8 consecutive valid cycles, o_first on 0x10, o_last on 0x17.
- Same burst, i_stall held for 4 cycles while 0x12 is presented -> 0x12 is held stable and o_fifo_rd_en = 0 for those cycles; sequence continues 0x13..0x17 with no duplicate or loss.
- 16 words preloaded -> two bursts of 8 with exactly one non-popping cycle between the last pop of burst 1 and the first pop of burst 2.
- rst pulsed after 3 words are popped -> all outputs 0 in the same cycle. The FIFO retains 5 words. After release, with 3 more words written, a new burst pops the 5 retained words first, then the 3 new ones.
- i_enable = 0 with 20 words present -> no pops. Raise i_enable -> exactly 2 bursts and 4 words left. Drop i_enable mid-burst 2 -> burst 2 still completes.
- With FIFO_RD_BURST_HDR_EN: two bursts -> headers 0xA5000000 then 0xA5000001, each with o_first = 1 and followed by 8 data words with o_last on the 8th. Force seq to 0xFFFF -> next header 0xA500FFFF, the one after 0xA5000000.
